// File: rtl/fp_sched_pkg.sv
// Shared types and float-format constants for the adder scheduler.
// Format: 1b sign, 6b exponent (bias 31), 25b mantissa.
package fp_sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    CAPTURE,
    RESPOND
  } sched_state_t;

  localparam int FP_W     = 32;
  localparam int EXP_W    = 6;
  localparam int MAN_W    = 25;
  localparam int EXP_BIAS = 31;
  localparam int STATUS_W = 4;

  localparam logic [FP_W-1:0] FP_ONE = 32'h3E00_0000;
  localparam logic [FP_W-1:0] FP_TWO = 32'h4000_0000;

endpackage

// File: rtl/fp_add_scheduler_arb.sv
// Combinational round-robin pick: first requester after ptr_i,
// wrapping modulo N.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  grant_o,
  output logic [IW-1:0] idx_o
);

  logic [IW:0] s;

  // Walk from farthest to nearest so the nearest hit wins.
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    s       = '0;
    for (int k = N; k >= 1; k--) begin
      s = {1'b0, ptr_i} + (IW+1)'(k);
      if (s >= (IW+1)'(N))
        s = s - (IW+1)'(N);
      if (req_i[s[IW-1:0]]) begin
        grant_o = '0;
        grant_o[s[IW-1:0]] = 1'b1;
        idx_o = s[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/fp_add_scheduler.sv
// Shares one fixed-latency float adder among N_REQ requesters:
// round-robin accept, restart adder, wait, capture, respond.
module fp_add_scheduler
  import fp_sched_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int LATENCY = 12
) (
  input  logic                     clock_100kHz,
  input  logic                     reset,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [N_REQ*FP_W-1:0]    req_op_a,
  input  logic [N_REQ*FP_W-1:0]    req_op_b,
  output logic [N_REQ-1:0]         req_ready,
  output logic [N_REQ-1:0]         rsp_valid,
  input  logic [N_REQ-1:0]         rsp_ready,
  output logic [FP_W-1:0]          rsp_data,
  output logic [STATUS_W-1:0]      rsp_status,
  output logic [FP_W-1:0]          fpu_op_a,
  output logic [FP_W-1:0]          fpu_op_b,
  output logic                     fpu_restart,
  input  logic [FP_W-1:0]          fpu_data,
  input  logic [STATUS_W-1:0]      fpu_status,
  output logic                     busy
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = $clog2(LATENCY + 1);

  sched_state_t     state_q;
  logic [IW-1:0]    rr_q;
  logic [IW-1:0]    gnt_q;
  logic [CW-1:0]    cnt_q;
  logic [N_REQ-1:0] arb_gnt;
  logic [IW-1:0]    arb_idx;

  rr_arbiter #(
    .N  (N_REQ),
    .IW (IW)
  ) u_arb (
    .req_i   (req_valid),
    .ptr_i   (rr_q),
    .grant_o (arb_gnt),
    .idx_o   (arb_idx)
  );

  // The operand bus doubles as the operand latch; it only moves on accept.
  always_ff @(posedge clock_100kHz) begin
    if (reset) begin
      state_q     <= IDLE;
      rr_q        <= IW'(N_REQ - 1);
      gnt_q       <= '0;
      cnt_q       <= '0;
      req_ready   <= '0;
      rsp_valid   <= '0;
      rsp_data    <= '0;
      rsp_status  <= '0;
      fpu_op_a    <= '0;
      fpu_op_b    <= '0;
      fpu_restart <= 1'b0;
      busy        <= 1'b0;
    end else begin
      req_ready   <= '0;
      fpu_restart <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (|req_valid) begin
            req_ready <= arb_gnt;
            gnt_q     <= arb_idx;
            rr_q      <= arb_idx;
            fpu_op_a  <= req_op_a[FP_W*int'(arb_idx) +: FP_W];
            fpu_op_b  <= req_op_b[FP_W*int'(arb_idx) +: FP_W];
            busy      <= 1'b1;
            state_q   <= ISSUE;
          end
        end
        ISSUE: begin
          fpu_restart <= 1'b1;
          cnt_q       <= '0;
          state_q     <= WAIT;
        end
        // Count LATENCY full cycles after the restart pulse drops.
        WAIT: begin
          if (cnt_q == CW'(LATENCY))
            state_q <= CAPTURE;
          else
            cnt_q <= cnt_q + CW'(1);
        end
        CAPTURE: begin
          rsp_data   <= fpu_data;
          rsp_status <= fpu_status;
          rsp_valid  <= N_REQ'(1) << gnt_q;
          state_q    <= RESPOND;
        end
        RESPOND: begin
          if (rsp_ready[gnt_q]) begin
            rsp_valid <= '0;
            busy      <= 1'b0;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_add_scheduler.sv
// Bench for fp_add_scheduler with a behavioural fixed-latency adder
// and a real-arithmetic reference for results.
module tb_fp_add_scheduler;
  import fp_sched_pkg::*;

  localparam int N = 4;
  localparam int L = 12;

  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  req_valid, req_ready, rsp_valid, rsp_ready;
  logic [N*32-1:0] req_op_a, req_op_b;
  logic [31:0]   rsp_data, fpu_op_a, fpu_op_b;
  logic [31:0]   fpu_data = 32'h0;
  logic [3:0]    rsp_status;
  logic [3:0]    fpu_status = 4'h0;
  logic          fpu_restart, busy;

  int checks = 0;
  int errors = 0;
  int acnt = L;
  int unsigned tcyc = 0;
  int ptr_m;

  always #5 clk = ~clk;
  always @(posedge clk) tcyc <= tcyc + 1;

  fp_add_scheduler #(.N_REQ(N), .LATENCY(L)) dut (
    .clock_100kHz (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_op_a     (req_op_a),
    .req_op_b     (req_op_b),
    .req_ready    (req_ready),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_data     (rsp_data),
    .rsp_status   (rsp_status),
    .fpu_op_a     (fpu_op_a),
    .fpu_op_b     (fpu_op_b),
    .fpu_restart  (fpu_restart),
    .fpu_data     (fpu_data),
    .fpu_status   (fpu_status),
    .busy         (busy)
  );

  function automatic real fp2r(logic [31:0] x);
    real m;
    int e;
    m = 1.0 + real'(x[24:0]) / 33554432.0;
    e = int'(x[30:25]) - 31;
    while (e > 0) begin m = m * 2.0; e--; end
    while (e < 0) begin m = m / 2.0; e++; end
    return x[31] ? -m : m;
  endfunction

  function automatic logic [31:0] r2fp(real v);
    logic s;
    real m;
    int e;
    logic [24:0] man;
    if (v == 0.0) return 32'h0;
    s = (v < 0.0);
    m = s ? -v : v;
    e = 31;
    while (m >= 2.0) begin m = m / 2.0; e++; end
    while (m < 1.0) begin m = m * 2.0; e--; end
    man = 25'($rtoi((m - 1.0) * 33554432.0));
    return {s, 6'(e), man};
  endfunction

  function automatic logic [31:0] fadd(logic [31:0] a, logic [31:0] b);
    return r2fp(fp2r(a) + fp2r(b));
  endfunction

  function automatic logic [3:0] fstat(logic [31:0] r);
    return {2'b00, r[31], (r == 32'h0)};
  endfunction

  function automatic logic [31:0] rnd_fp();
    logic [5:0] e;
    e = 6'($urandom_range(24, 38));
    return {1'($urandom), e, 25'($urandom)};
  endfunction

  function automatic int rr_next(logic [N-1:0] v, int p);
    for (int k = 1; k <= N; k++)
      if (v[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  // Adder: result appears after L edges with restart low.
  always @(posedge clk) begin
    if (fpu_restart) begin
      acnt       <= 0;
      fpu_data   <= 32'hDEAD_BEEF;
      fpu_status <= 4'hA;
    end else if (acnt < L) begin
      acnt <= acnt + 1;
      if (acnt == L - 1) begin
        fpu_data   <= fadd(fpu_op_a, fpu_op_b);
        fpu_status <= fstat(fadd(fpu_op_a, fpu_op_b));
      end
    end
  end

  task automatic wait_ready(output int n);
    n = -1;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (req_ready != 0) begin n = k; return; end
    end
  endtask

  task automatic wait_rsp(output int n);
    n = -1;
    for (int k = 1; k <= L + 10; k++) begin
      @(negedge clk);
      if (rsp_valid != 0) begin n = k; return; end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req_valid = '0;
    rsp_ready = '0;
    req_op_a = '0;
    req_op_b = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (req_ready !== 4'b0 || rsp_valid !== 4'b0) begin
      errors++;
      $display("FAIL reset_hs got rdy=%b vld=%b exp 0", req_ready, rsp_valid);
    end
    checks++;
    if (busy !== 1'b0 || fpu_restart !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctl got busy=%b rst=%b exp 0", busy, fpu_restart);
    end
    checks++;
    if (rsp_data !== 32'h0 || rsp_status !== 4'h0) begin
      errors++;
      $display("FAIL reset_rsp got %h/%h exp 0", rsp_data, rsp_status);
    end
    checks++;
    if (fpu_op_a !== 32'h0 || fpu_op_b !== 32'h0) begin
      errors++;
      $display("FAIL reset_ops got %h/%h exp 0", fpu_op_a, fpu_op_b);
    end
    reset = 1'b0;
    ptr_m = N - 1;
  endtask

  task automatic test_single();
    int n;
    @(negedge clk);
    req_op_a[31:0] = FP_ONE;
    req_op_b[31:0] = FP_TWO;
    req_valid = 4'b0001;
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0001 || fpu_restart !== 1'b0) begin
      errors++;
      $display("FAIL single_accept got %b/%b exp 0001/0", req_ready, fpu_restart);
    end
    req_valid = '0;
    @(negedge clk);
    checks++;
    if (fpu_restart !== 1'b1 || req_ready !== 4'b0 || fpu_op_a !== FP_ONE) begin
      errors++;
      $display("FAIL single_restart got r=%b rdy=%b a=%h exp 1/0/%h",
               fpu_restart, req_ready, fpu_op_a, FP_ONE);
    end
    @(negedge clk);
    checks++;
    if (fpu_restart !== 1'b0) begin
      errors++;
      $display("FAIL single_pulse got %b exp 0", fpu_restart);
    end
    n = -1;
    for (int k = 3; k <= L + 10; k++) begin
      @(negedge clk);
      if (rsp_valid != 0) begin n = k; break; end
    end
    checks++;
    if (n != L + 3) begin
      errors++;
      $display("FAIL single_latency got %0d exp %0d", n, L + 3);
    end
    checks++;
    if (rsp_valid !== 4'b0001 || rsp_data !== 32'h4100_0000 || rsp_status !== 4'h0) begin
      errors++;
      $display("FAIL single_data got %b %h %h exp 0001 41000000 0",
               rsp_valid, rsp_data, rsp_status);
    end
    rsp_ready = 4'b0001;
    @(negedge clk);
    rsp_ready = '0;
    checks++;
    if (rsp_valid !== 4'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL single_done got vld=%b busy=%b exp 0/0", rsp_valid, busy);
    end
    ptr_m = 0;
  endtask

  task automatic test_round_robin();
    logic [31:0] ea, eb;
    int g, n;
    int unsigned last_t;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    ptr_m = N - 1;
    for (int i = 0; i < N; i++) begin
      req_op_a[32*i +: 32] = rnd_fp();
      req_op_b[32*i +: 32] = rnd_fp();
    end
    req_valid = '1;
    rsp_ready = '1;
    last_t = 0;
    for (int op = 0; op < 8; op++) begin
      wait_ready(n);
      g = rr_next(req_valid, ptr_m);
      checks++;
      if (n < 0 || req_ready !== (4'b1 << g)) begin
        errors++;
        $display("FAIL rr_grant op=%0d got %b exp %b", op, req_ready, 4'b1 << g);
      end
      if (op > 0) begin
        checks++;
        if (tcyc - last_t != L + 5) begin
          errors++;
          $display("FAIL rr_gap op=%0d got %0d exp %0d", op, tcyc - last_t, L + 5);
        end
      end
      last_t = tcyc;
      ea = req_op_a[32*g +: 32];
      eb = req_op_b[32*g +: 32];
      ptr_m = g;
      req_op_a[32*g +: 32] = rnd_fp();
      req_op_b[32*g +: 32] = rnd_fp();
      wait_rsp(n);
      checks++;
      if (n < 0 || rsp_valid !== (4'b1 << g) || rsp_data !== fadd(ea, eb) ||
          rsp_status !== fstat(fadd(ea, eb))) begin
        errors++;
        $display("FAIL rr_rsp op=%0d got %b %h %h exp %b %h %h", op, rsp_valid,
                 rsp_data, rsp_status, 4'b1 << g, fadd(ea, eb), fstat(fadd(ea, eb)));
      end
    end
    req_valid = '0;
    repeat (2) @(negedge clk);
    rsp_ready = '0;
  endtask

  task automatic test_backpressure();
    logic [31:0] ea, eb, hd;
    logic [3:0] hs;
    int n, g;
    req_op_a[63:32] = rnd_fp();
    req_op_b[63:32] = rnd_fp();
    req_valid = 4'b0010;
    wait_ready(n);
    checks++;
    if (n < 0 || req_ready !== 4'b0010) begin
      errors++;
      $display("FAIL bp_grant got %b exp 0010", req_ready);
    end
    ea = req_op_a[63:32];
    eb = req_op_b[63:32];
    ptr_m = 1;
    req_valid = 4'b1001;
    wait_rsp(n);
    checks++;
    if (n < 0 || rsp_valid !== 4'b0010 || rsp_data !== fadd(ea, eb)) begin
      errors++;
      $display("FAIL bp_rsp got %b %h exp 0010 %h", rsp_valid, rsp_data, fadd(ea, eb));
    end
    hd = fadd(ea, eb);
    hs = fstat(hd);
    rsp_ready = 4'b1101;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      checks++;
      if (rsp_valid !== 4'b0010 || rsp_data !== hd || rsp_status !== hs ||
          busy !== 1'b1 || req_ready !== 4'b0) begin
        errors++;
        $display("FAIL bp_hold k=%0d got %b %h %h busy=%b rdy=%b exp 0010 %h %h 1 0000",
                 k, rsp_valid, rsp_data, rsp_status, busy, req_ready, hd, hs);
      end
    end
    rsp_ready = 4'b0010;
    @(negedge clk);
    rsp_ready = '0;
    checks++;
    if (rsp_valid !== 4'b0 || req_ready !== 4'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL bp_release got %b %b %b exp 0 0 0", rsp_valid, req_ready, busy);
    end
    @(negedge clk);
    g = rr_next(4'b1001, ptr_m);
    checks++;
    if (req_ready !== (4'b1 << g)) begin
      errors++;
      $display("FAIL bp_next got %b exp %b", req_ready, 4'b1 << g);
    end
    ptr_m = g;
    req_valid = '0;
  endtask

  task automatic test_reset_in_wait();
    logic [31:0] ea, eb;
    int n;
    repeat (4) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL rw_busy got %b exp 1", busy);
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0 || rsp_valid !== 4'b0 || busy !== 1'b0 ||
        fpu_restart !== 1'b0 || rsp_data !== 32'h0 || fpu_op_a !== 32'h0) begin
      errors++;
      $display("FAIL rw_abort got %b %b %b %b %h %h exp all 0", req_ready,
               rsp_valid, busy, fpu_restart, rsp_data, fpu_op_a);
    end
    req_op_a[31:0] = rnd_fp();
    req_op_b[31:0] = rnd_fp();
    req_op_a[127:96] = rnd_fp();
    req_op_b[127:96] = rnd_fp();
    reset = 1'b0;
    req_valid = 4'b1001;
    ptr_m = N - 1;
    wait_ready(n);
    checks++;
    if (n < 0 || req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL rw_first got %b exp 0001", req_ready);
    end
    ea = req_op_a[31:0];
    eb = req_op_b[31:0];
    req_valid = 4'b1000;
    wait_rsp(n);
    checks++;
    if (n < 0 || rsp_valid !== 4'b0001 || rsp_data !== fadd(ea, eb)) begin
      errors++;
      $display("FAIL rw_rsp got %b %h exp 0001 %h", rsp_valid, rsp_data, fadd(ea, eb));
    end
    rsp_ready = 4'b0001;
    wait_ready(n);
    rsp_ready = '0;
    checks++;
    if (n < 0 || req_ready !== 4'b1000) begin
      errors++;
      $display("FAIL rw_second got %b exp 1000", req_ready);
    end
    req_valid = '0;
    wait_rsp(n);
    rsp_ready = 4'b1000;
    @(negedge clk);
    rsp_ready = '0;
    ptr_m = 3;
  endtask

  task automatic test_drop_after_accept();
    logic [31:0] ea, eb;
    logic stable;
    int n;
    req_op_a[95:64] = rnd_fp();
    req_op_b[95:64] = rnd_fp();
    req_valid = 4'b0100;
    wait_ready(n);
    checks++;
    if (n < 0 || req_ready !== 4'b0100) begin
      errors++;
      $display("FAIL drop_grant got %b exp 0100", req_ready);
    end
    ea = req_op_a[95:64];
    eb = req_op_b[95:64];
    req_valid = '0;
    req_op_a[95:64] = ~ea;
    req_op_b[95:64] = ~eb;
    stable = 1'b1;
    n = -1;
    for (int k = 1; k <= L + 10; k++) begin
      @(negedge clk);
      if (fpu_op_a !== ea || fpu_op_b !== eb) stable = 1'b0;
      if (rsp_valid != 0) begin n = k; break; end
    end
    checks++;
    if (stable !== 1'b1) begin
      errors++;
      $display("FAIL drop_ops got %h/%h exp %h/%h", fpu_op_a, fpu_op_b, ea, eb);
    end
    checks++;
    if (n != L + 3 || rsp_valid !== 4'b0100 || rsp_data !== fadd(ea, eb)) begin
      errors++;
      $display("FAIL drop_rsp got n=%0d %b %h exp n=%0d 0100 %h",
               n, rsp_valid, rsp_data, L + 3, fadd(ea, eb));
    end
    rsp_ready = 4'b0100;
    @(negedge clk);
    rsp_ready = '0;
    @(negedge clk);
    checks++;
    if (rsp_valid !== 4'b0 || busy !== 1'b0 || fpu_op_a !== ea) begin
      errors++;
      $display("FAIL drop_idle got %b %b %h exp 0 0 %h", rsp_valid, busy, fpu_op_a, ea);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_reset_in_wait();
    test_drop_after_accept();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got running exp finished");
    $fatal(1, "timeout");
  end

endmodule
